// File: rtl/dcs_pkg.sv
`timescale 1ns/1ps
// dcs_pkg: constants and types shared by the DCSformer host, the attention
// core wrapper and its bench.
//   N_IN  : bytes per input matrix (8 tokens x 16 features)
//   N_W   : weight bytes per transaction
//   N_OUT : 32-bit result words per transaction
//   state_t : host transaction state
package dcs_pkg;

    localparam int N_IN  = 128;
    localparam int N_W   = 8;
    localparam int N_OUT = 8;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND_I  = 3'd1,
        WAIT_WR = 3'd2,
        SEND_W  = 3'd3,
        WAIT_O  = 3'd4,
        RECV    = 3'd5
    } state_t;

endpackage

// File: rtl/dcs_byte_buf.sv
`timescale 1ns/1ps
// dcs_byte_buf: DEPTH x WIDTH register file, one synchronous write port and
// one combinational read port. A read of the entry being written in the same
// cycle returns the old contents.
//   clk, rst      : clock, asynchronous active-high reset (only used when
//                   RESET_EN=1, which clears every entry to zero)
//   we/waddr/wdata: write port
//   raddr/rdata   : combinational read port
module dcs_byte_buf #(
    parameter  int DEPTH    = 8,
    parameter  int WIDTH    = 8,
    parameter  bit RESET_EN = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    generate
        if (RESET_EN) begin : g_rst
            // Storage with asynchronous clear to zero.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        mem_q[i] <= '0;
                    end
                end else if (we) begin
                    mem_q[waddr] <= wdata;
                end
            end
        end else begin : g_nrst
            logic unused_rst_s;
            assign unused_rst_s = rst;

            // Storage without reset; contents survive rst.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem_q[waddr] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/dcsformer_host.sv
`timescale 1ns/1ps
// dcsformer_host: transaction initiator for the DCSformer attention core.
// Holds a locally loaded 128-byte token matrix and 8-byte weight vector. A
// start pulse streams the matrix on i_valid/i_data, waits for w_ready,
// streams the weights on w_valid/w_data, then captures eight o_data words
// into a result buffer readable through rd_addr/rd_data.
//   clk, rst               : clock, asynchronous active-high reset
//   ld_en/ld_sel/ld_addr/ld_data : buffer load port (ignored while busy)
//   start, busy, done, err_timeout : transaction control/status
//   rd_addr, rd_data       : combinational result-buffer read
//   i_valid/i_data, w_valid/w_data : streams to the core
//   w_ready, o_valid/o_data : handshakes/results from the core
module dcsformer_host
    import dcs_pkg::*;
#(
    parameter logic [9:0] TIMEOUT = 10'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_en,
    input  logic        ld_sel,
    input  logic [6:0]  ld_addr,
    input  logic [7:0]  ld_data,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err_timeout,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        i_valid,
    output logic [7:0]  i_data,
    output logic        w_valid,
    output logic [7:0]  w_data,
    input  logic        w_ready,
    input  logic        o_valid,
    input  logic [31:0] o_data
);

    state_t      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        i_valid_q, i_valid_d;
    byte_t       i_data_q, i_data_d;
    logic        w_valid_q, w_valid_d;
    byte_t       w_data_q, w_data_d;
    logic [7:0]  icnt_q, icnt_d;
    logic [2:0]  wcnt_q, wcnt_d;
    logic [2:0]  rcnt_q, rcnt_d;
    logic [9:0]  to_q, to_d;

    logic        ld_ok_s;
    logic        in_we_s;
    logic        w_we_s;
    logic        res_we_s;
    logic [6:0]  in_raddr_s;
    logic [2:0]  w_raddr_s;
    byte_t       in_rdata_s;
    byte_t       w_rdata_s;
    byte_t       first_byte_s;
    logic [9:0]  to_inc_s;
    logic        i_last_s;
    logic        w_last_s;
    logic        r_last_s;

    // Loads are only accepted while no transaction is in flight.
    assign ld_ok_s  = ld_en & ~busy_q;
    assign in_we_s  = ld_ok_s & ~ld_sel;
    assign w_we_s   = ld_ok_s & ld_sel;

    assign i_last_s = (icnt_q == 8'(N_IN - 1));
    assign w_last_s = (wcnt_q == 3'(N_W - 1));
    assign r_last_s = (rcnt_q == 3'(N_OUT - 1));
    assign to_inc_s = to_q + 10'd1;

    // Output registers hold the byte for the current index, so the buffers
    // are read one entry ahead; the first entry is read while waiting.
    assign in_raddr_s = (state_q == IDLE) ? 7'd0 : (icnt_q[6:0] + 7'd1);
    assign w_raddr_s  = (state_q == WAIT_WR) ? 3'd0 : (wcnt_q + 3'd1);

    // A load to byte 0 in the start cycle has not reached the buffer yet,
    // so forward it straight into the first streamed byte.
    assign first_byte_s = (in_we_s && (ld_addr == 7'd0)) ? ld_data : in_rdata_s;

    dcs_byte_buf #(.DEPTH(N_IN), .WIDTH(8), .RESET_EN(1'b0)) u_in_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (in_we_s),
        .waddr (ld_addr),
        .wdata (ld_data),
        .raddr (in_raddr_s),
        .rdata (in_rdata_s)
    );

    dcs_byte_buf #(.DEPTH(N_W), .WIDTH(8), .RESET_EN(1'b0)) u_w_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (w_we_s),
        .waddr (ld_addr[2:0]),
        .wdata (ld_data),
        .raddr (w_raddr_s),
        .rdata (w_rdata_s)
    );

    dcs_byte_buf #(.DEPTH(N_OUT), .WIDTH(32), .RESET_EN(1'b1)) u_res_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (res_we_s),
        .waddr (rcnt_q),
        .wdata (o_data),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        i_valid_d = i_valid_q;
        i_data_d  = i_data_q;
        w_valid_d = w_valid_q;
        w_data_d  = w_data_q;
        icnt_d    = icnt_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        to_d      = to_q;
        res_we_s  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = SEND_I;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    i_valid_d = 1'b1;
                    i_data_d  = first_byte_s;
                    icnt_d    = 8'd0;
                    wcnt_d    = 3'd0;
                    rcnt_d    = 3'd0;
                    to_d      = 10'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND_I: begin
                if (i_last_s) begin
                    state_d   = WAIT_WR;
                    i_valid_d = 1'b0;
                    i_data_d  = 8'd0;
                    to_d      = 10'd0;
                end else begin
                    icnt_d   = icnt_q + 8'd1;
                    i_data_d = in_rdata_s;
                end
            end
            WAIT_WR: begin
                if (w_ready) begin
                    state_d   = SEND_W;
                    w_valid_d = 1'b1;
                    w_data_d  = w_rdata_s;
                    wcnt_d    = 3'd0;
                    to_d      = 10'd0;
                end else if (to_inc_s == TIMEOUT) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    err_d     = 1'b1;
                    i_valid_d = 1'b0;
                    w_valid_d = 1'b0;
                    to_d      = 10'd0;
                end else begin
                    to_d = to_inc_s;
                end
            end
            SEND_W: begin
                if (w_last_s) begin
                    state_d   = WAIT_O;
                    w_valid_d = 1'b0;
                    w_data_d  = 8'd0;
                    to_d      = 10'd0;
                end else begin
                    wcnt_d   = wcnt_q + 3'd1;
                    w_data_d = w_rdata_s;
                end
            end
            WAIT_O, RECV: begin
                if (o_valid) begin
                    res_we_s = 1'b1;
                    to_d     = 10'd0;
                    if (r_last_s) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        rcnt_d  = 3'd0;
                    end else begin
                        state_d = RECV;
                        rcnt_d  = rcnt_q + 3'd1;
                    end
                end else if (to_inc_s == TIMEOUT) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    err_d     = 1'b1;
                    i_valid_d = 1'b0;
                    w_valid_d = 1'b0;
                    to_d      = 10'd0;
                end else begin
                    to_d = to_inc_s;
                end
            end
            default: begin
                state_d   = IDLE;
                busy_d    = 1'b0;
                i_valid_d = 1'b0;
                w_valid_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            i_valid_q <= 1'b0;
            i_data_q  <= 8'd0;
            w_valid_q <= 1'b0;
            w_data_q  <= 8'd0;
            icnt_q    <= 8'd0;
            wcnt_q    <= 3'd0;
            rcnt_q    <= 3'd0;
            to_q      <= 10'd0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            i_valid_q <= i_valid_d;
            i_data_q  <= i_data_d;
            w_valid_q <= w_valid_d;
            w_data_q  <= w_data_d;
            icnt_q    <= icnt_d;
            wcnt_q    <= wcnt_d;
            rcnt_q    <= rcnt_d;
            to_q      <= to_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign i_valid     = i_valid_q;
    assign i_data      = i_data_q;
    assign w_valid     = w_valid_q;
    assign w_data      = w_data_q;

endmodule
